// File: rtl/nubus_mst_sched.sv
// Round-robin scheduler that shares one NuBus master port between N_REQ local requesters,
// with lock hold for read-modify-write sequences and bounded try-again re-issue.
module nubus_mst_sched #(
    parameter int  N_REQ       = 4,
    parameter int  RETRY_MAX   = 3,
    parameter int  BACKOFF_CYC = 8,
    localparam int IW          = $clog2(N_REQ)
) (
    input  logic                 nub_clk,
    input  logic                 nub_reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*32-1:0]  req_addr,
    input  logic [N_REQ*32-1:0]  req_wdata,
    input  logic [N_REQ*4-1:0]   req_write,
    input  logic [N_REQ-1:0]     req_lock,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     req_error,
    output logic [31:0]          req_rdata,
    output logic                 mst_valid,
    output logic [31:0]          mst_addr,
    output logic [31:0]          mst_wdata,
    output logic [3:0]           mst_write,
    output logic                 mst_lock,
    input  logic                 mst_ready,
    input  logic [31:0]          mst_rdata,
    input  logic                 mst_err,
    input  logic                 mst_retry,
    output logic                 sch_busy,
    output logic [IW-1:0]        sch_owner,
    output logic [1:0]           sch_state
);

    localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        BACKOFF = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_ptr;
    logic [RW-1:0]   retry_cnt;
    logic [7:0]      backoff_cnt;
    logic            locked;
    logic            lock_held;

    logic [31:0]     addr_a  [N_REQ];
    logic [31:0]     wdata_a [N_REQ];
    logic [3:0]      strb_a  [N_REQ];
    logic [IW-1:0]   cand;
    logic [IW-1:0]   rr_pick;
    logic            any_valid;
    logic            keep_lock;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   owner_next;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_a[i]  = req_addr[32*i +: 32];
            wdata_a[i] = req_wdata[32*i +: 32];
            strb_a[i]  = req_write[4*i +: 4];
        end
    end

    // Walk downward so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        cand      = '0;
        rr_pick   = rr_ptr;
        any_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IW'((int'(rr_ptr) + k) % N_REQ);
            if (req_valid[cand]) begin
                rr_pick   = cand;
                any_valid = 1'b1;
            end
        end
    end

    assign keep_lock  = locked & req_valid[owner] & req_lock[owner];
    assign grant      = keep_lock ? owner : rr_pick;
    assign owner_next = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;

    // Handshake: requesters hold req_valid and payload until their one-cycle req_ready;
    // the master port sees mst_valid held in ISSUE and completes on a single mst_ready cycle.
    always_ff @(posedge nub_clk or posedge nub_reset) begin
        if (nub_reset) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            retry_cnt   <= '0;
            backoff_cnt <= '0;
            locked      <= 1'b0;
            lock_held   <= 1'b0;
            mst_valid   <= 1'b0;
            mst_addr    <= '0;
            mst_wdata   <= '0;
            mst_write   <= '0;
            req_ready   <= '0;
            req_error   <= '0;
            req_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!keep_lock) begin
                        locked <= 1'b0;
                    end
                    if (keep_lock || any_valid) begin
                        owner     <= grant;
                        lock_held <= req_lock[grant];
                        mst_addr  <= addr_a[grant];
                        mst_wdata <= wdata_a[grant];
                        mst_write <= strb_a[grant];
                        retry_cnt <= '0;
                        mst_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mst_ready) begin
                        mst_valid <= 1'b0;
                        if (mst_err) begin
                            req_ready[owner] <= 1'b1;
                            req_error[owner] <= 1'b1;
                            state            <= DONE;
                        end else if (mst_retry && (retry_cnt < RW'(RETRY_MAX))) begin
                            retry_cnt   <= retry_cnt + 1'b1;
                            backoff_cnt <= 8'(BACKOFF_CYC);
                            state       <= BACKOFF;
                        end else if (mst_retry) begin
                            req_ready[owner] <= 1'b1;
                            req_error[owner] <= 1'b1;
                            state            <= DONE;
                        end else begin
                            req_ready[owner] <= 1'b1;
                            req_rdata        <= mst_rdata;
                            state            <= DONE;
                        end
                    end
                end
                BACKOFF: begin
                    if (backoff_cnt == 8'd0) begin
                        mst_valid <= 1'b1;
                        state     <= ISSUE;
                    end else begin
                        backoff_cnt <= backoff_cnt - 1'b1;
                    end
                end
                DONE: begin
                    req_ready <= '0;
                    req_error <= '0;
                    // A locked owner keeps the pointer so the next pass can return to it.
                    if (lock_held) begin
                        locked <= 1'b1;
                    end else begin
                        locked <= 1'b0;
                        rr_ptr <= owner_next;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mst_lock  = locked | (lock_held & (state != IDLE));
    assign sch_busy  = (state != IDLE);
    assign sch_owner = owner;
    assign sch_state = state;

endmodule

// File: tb/tb_nubus_mst_sched.sv
// Bench for nubus_mst_sched: acts as requesters and slave, predicts grants and outcomes
// from a transaction-level model of the arbitration, retry and lock rules.
module tb_nubus_mst_sched;

    localparam int N    = 4;
    localparam int RMAX = 3;
    localparam int BCYC = 8;

    logic              nub_clk = 1'b0;
    logic              nub_reset;
    logic [N-1:0]      req_valid;
    logic [N*32-1:0]   req_addr;
    logic [N*32-1:0]   req_wdata;
    logic [N*4-1:0]    req_write;
    logic [N-1:0]      req_lock;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_error;
    logic [31:0]       req_rdata;
    logic              mst_valid;
    logic [31:0]       mst_addr;
    logic [31:0]       mst_wdata;
    logic [3:0]        mst_write;
    logic              mst_lock;
    logic              mst_ready;
    logic [31:0]       mst_rdata;
    logic              mst_err;
    logic              mst_retry;
    logic              sch_busy;
    logic [1:0]        sch_owner;
    logic [1:0]        sch_state;

    nubus_mst_sched #(.N_REQ(N), .RETRY_MAX(RMAX), .BACKOFF_CYC(BCYC)) dut (
        .nub_clk   (nub_clk),
        .nub_reset (nub_reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_write (req_write),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .req_error (req_error),
        .req_rdata (req_rdata),
        .mst_valid (mst_valid),
        .mst_addr  (mst_addr),
        .mst_wdata (mst_wdata),
        .mst_write (mst_write),
        .mst_lock  (mst_lock),
        .mst_ready (mst_ready),
        .mst_rdata (mst_rdata),
        .mst_err   (mst_err),
        .mst_retry (mst_retry),
        .sch_busy  (sch_busy),
        .sch_owner (sch_owner),
        .sch_state (sch_state)
    );

    // ---------------- clock / reset ----------------
    always #5 nub_clk = ~nub_clk;

    // ---------------- requester payload storage ----------------
    logic [31:0] addr_of  [N];
    logic [31:0] wdata_of [N];
    logic [3:0]  strb_of  [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[32*i +: 32] = addr_of[i];
            req_wdata[32*i +: 32] = wdata_of[i];
            req_write[4*i +: 4]   = strb_of[i];
        end
    end

    // ---------------- scoreboard / model state ----------------
    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          m_rr = 0;
    bit          m_locked = 1'b0;
    int          m_owner = 0;
    logic [31:0] m_rdata = '0;

    int           script [8];
    int           lat_fix = -1;
    bit           rd_fixed = 1'b0;
    logic [31:0]  rd_fix = '0;
    logic [N-1:0] drop_after = '0;
    logic [N-1:0] drop_lock_after = '0;
    bit           arm_watch = 1'b0;
    bit           disarm_watch = 1'b0;
    bit           lock_watch = 1'b0;
    int           multi_hot = 0;
    int           lock_drops = 0;

    always @(negedge nub_clk) begin
        if (!nub_reset) begin
            if ($countones(req_ready) > 1) multi_hot++;
            if (lock_watch && !mst_lock) lock_drops++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Arbitration rule: a held lock keeps the owner, otherwise first valid upward from rr.
    function automatic int model_pick();
        if (m_locked && req_valid[m_owner] && req_lock[m_owner]) return m_owner;
        m_locked = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge nub_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit lk);
        addr_of[i]   = a;
        wdata_of[i]  = d;
        strb_of[i]   = s;
        req_lock[i]  = lk;
        req_valid[i] = 1'b1;
    endtask

    task automatic set_req_rand(input int i);
        set_req(i, $urandom(), $urandom(), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    endtask

    task automatic rand_script();
        int v;
        for (int j = 0; j < 8; j++) begin
            v = int'($urandom_range(0, 9));
            script[j] = (v <= 5) ? 0 : (v <= 7) ? 1 : (v == 8) ? 2 : 3;
        end
    endtask

    // Serves one transfer as the slave; status code 0 ok, 1 retry, 2 err, 3 err+retry.
    task automatic serve();
        int          exp_idx;
        int          waited;
        int          k;
        int          low;
        int          st;
        bit          done;
        bit          exp_err;
        bit          lk;
        logic [31:0] rd;
        exp_idx = int'(exp_q.pop_front());
        lk      = req_lock[exp_idx];
        waited  = 0;
        do begin
            step();
            waited++;
        end while (!mst_valid && waited < 8);
        check("grant_lat", waited, 1);
        if (!mst_valid) return;
        if (arm_watch) lock_watch = 1'b1;
        check("owner", 32'(sch_owner), exp_idx);
        check("addr", mst_addr, addr_of[exp_idx]);
        check("wdata", mst_wdata, wdata_of[exp_idx]);
        check("strb", 32'(mst_write), 32'(strb_of[exp_idx]));
        check("lock_issue", 32'(mst_lock), 32'(lk));
        k       = 0;
        done    = 1'b0;
        exp_err = 1'b0;
        while (!done) begin
            repeat ((lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3))) step();
            check("valid_hold", 32'(mst_valid), 1);
            rd        = rd_fixed ? rd_fix : $urandom();
            st        = script[k];
            mst_rdata = rd;
            mst_ready = 1'b1;
            mst_err   = (st >= 2);
            mst_retry = (st == 1) || (st == 3);
            step();
            mst_ready = 1'b0;
            mst_err   = 1'b0;
            mst_retry = 1'b0;
            if (st >= 2) begin
                done    = 1'b1;
                exp_err = 1'b1;
            end else if (st == 1 && k < RMAX) begin
                k++;
                check("retry_drop", 32'(mst_valid), 0);
                check("retry_noack", 32'(req_ready), 0);
                low = 0;
                while (!mst_valid && low < BCYC + 4) begin
                    low++;
                    mst_ready = 1'($urandom_range(0, 1));
                    mst_retry = 1'b1;
                    step();
                end
                mst_ready = 1'b0;
                mst_retry = 1'b0;
                check("backoff_len", low, BCYC + 1);
            end else if (st == 1) begin
                done    = 1'b1;
                exp_err = 1'b1;
            end else begin
                done    = 1'b1;
                m_rdata = rd;
            end
        end
        check("ready_vec", 32'(req_ready), 32'(1) << exp_idx);
        check("error_bit", 32'(req_error[exp_idx]), 32'(exp_err));
        check("rdata", req_rdata, m_rdata);
        check("done_valid", 32'(mst_valid), 0);
        m_owner = exp_idx;
        if (lk) begin
            m_locked = 1'b1;
        end else begin
            m_locked = 1'b0;
            m_rr     = (exp_idx + 1) % N;
        end
        req_valid = req_valid & ~drop_after;
        req_lock  = req_lock & ~drop_lock_after;
        if (disarm_watch) lock_watch = 1'b0;
        mst_ready = 1'b1;
        mst_err   = 1'b1;
        step();
        mst_ready = 1'b0;
        mst_err   = 1'b0;
        check("ready_pulse", 32'(req_ready), 0);
        check("idle_busy", 32'(sch_busy), 0);
        check("idle_lock", 32'(mst_lock), 32'(m_locked));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int o;
        nub_reset = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        mst_ready = 1'b0;
        mst_rdata = '0;
        mst_err   = 1'b0;
        mst_retry = 1'b0;
        for (int i = 0; i < N; i++) begin
            addr_of[i]  = '0;
            wdata_of[i] = '0;
            strb_of[i]  = '0;
        end
        repeat (3) step();
        check("rst_valid", 32'(mst_valid), 0);
        check("rst_lock", 32'(mst_lock), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_error", 32'(req_error), 0);
        check("rst_rdata", req_rdata, 0);
        check("rst_busy", 32'(sch_busy), 0);
        check("rst_owner", 32'(sch_owner), 0);
        check("rst_addr", mst_addr, 0);
        check("rst_state", 32'(sch_state), 0);
        @(posedge nub_clk);
        #3 nub_reset = 1'b0;

        // single read by requester 1
        set_req(1, 32'hF100_0000, 32'h1234_5678, 4'b0000, 1'b0);
        script[0] = 0;
        lat_fix = 2;
        rd_fixed = 1'b1;
        rd_fix = 32'hCAFE_BABE;
        drop_after = 4'b0010;
        exp_q.push_back(model_pick());
        serve();
        rd_fixed = 1'b0;

        // error wins over retry on requester 3
        set_req_rand(3);
        req_lock[3] = 1'b0;
        script[0] = 3;
        lat_fix = 0;
        drop_after = 4'b1000;
        exp_q.push_back(model_pick());
        serve();

        // round robin with all requesters held valid
        for (int i = 0; i < N; i++) begin
            set_req_rand(i);
            req_lock[i] = 1'b0;
        end
        for (int t = 0; t < 5; t++) begin
            script[0] = 0;
            lat_fix = -1;
            drop_after = (t == 4) ? 4'hF : 4'h0;
            exp_q.push_back(model_pick());
            serve();
        end

        // two retries then ok, then retries past the limit
        set_req(0, 32'hF200_0010, 32'hA5A5_0000, 4'b1111, 1'b0);
        script[0] = 1; script[1] = 1; script[2] = 0;
        lat_fix = 1;
        drop_after = 4'b0001;
        exp_q.push_back(model_pick());
        serve();
        set_req(1, 32'hF300_0020, 32'h0, 4'b0000, 1'b0);
        for (int j = 0; j < 8; j++) script[j] = 1;
        drop_after = 4'b0010;
        exp_q.push_back(model_pick());
        serve();

        // locked pair on requester 2 while requester 0 waits
        set_req(2, 32'hF400_0000, 32'h0, 4'b0000, 1'b1);
        set_req(0, 32'hF500_0000, 32'hDEAD_BEEF, 4'b0011, 1'b0);
        script[0] = 0;
        lat_fix = -1;
        arm_watch = 1'b1;
        drop_after = '0;
        drop_lock_after = '0;
        exp_q.push_back(model_pick());
        serve();
        wdata_of[2] = 32'h0000_00FF;
        strb_of[2] = 4'b0001;
        disarm_watch = 1'b1;
        drop_after = 4'b0100;
        drop_lock_after = 4'b0100;
        exp_q.push_back(model_pick());
        serve();
        arm_watch = 1'b0;
        disarm_watch = 1'b0;
        drop_lock_after = '0;
        drop_after = 4'b0001;
        exp_q.push_back(model_pick());
        serve();

        // randomized traffic
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req_rand(i);
            end
            if (req_valid == '0) set_req_rand(int'($urandom_range(0, N - 1)));
            rand_script();
            lat_fix = -1;
            o = model_pick();
            exp_q.push_back(o);
            drop_after = ($urandom_range(0, 1) == 1) ? (N'(1) << o) : '0;
            drop_lock_after = ($urandom_range(0, 1) == 1) ? (N'(1) << o) : '0;
            serve();
            if (req_valid[o]) set_req_rand(o);
        end
        req_valid = '0;
        req_lock = '0;
        drop_after = '0;
        drop_lock_after = '0;
        repeat (2) step();

        // reset in the middle of a locked transfer
        set_req(2, 32'hF600_0000, 32'h55AA_55AA, 4'b1111, 1'b1);
        step();
        check("rst_mid_pre", 32'(mst_valid), 1);
        #2 nub_reset = 1'b1;
        #1;
        check("rst_mid_valid", 32'(mst_valid), 0);
        check("rst_mid_lock", 32'(mst_lock), 0);
        check("rst_mid_busy", 32'(sch_busy), 0);
        check("rst_mid_owner", 32'(sch_owner), 0);
        check("rst_mid_rdata", req_rdata, 0);
        check("rst_mid_addr", mst_addr, 0);
        req_valid = '0;
        req_lock = '0;
        @(posedge nub_clk);
        #3 nub_reset = 1'b0;
        m_rr = 0;
        m_locked = 1'b0;
        m_owner = 0;
        m_rdata = '0;
        for (int i = 0; i < N; i++) begin
            set_req_rand(i);
            req_lock[i] = 1'b0;
        end
        script[0] = 0;
        drop_after = 4'hF;
        exp_q.push_back(model_pick());
        serve();

        // ---------------- final report ----------------
        check("exp_q_empty", exp_q.size(), 0);
        check("onehot_ready", multi_hot, 0);
        check("lock_hold", lock_drops, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
